zcomp_pipe: RTL and testbench

Parametrised, pipelined successor to the blitter's four-lane Z comparator. It compares LANES source-Z values against destination-Z values and applies the 3-bit Z mode to produce a per-lane inhibit mask. Transactions move through a valid/ready pipeline with a per-beat lane-enable mask, and a saturating counter tracks inhibited pixels. It sits between the blitter's Z source/destination data path and the write-inhibit logic, and can stall under back-pressure from the write stage.

---
 rtl/zcomp_pipe.sv | 147 ++++++++++++++
 tb/tb_zcomp_pipe.sv | 339 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/zcomp_pipe.sv
// zcomp_pipe -- two-stage valid/ready Z comparator with per-lane write inhibit.
//
// Compares LANES unsigned source-Z values against destination-Z values and
// applies the 3-bit Z mode to produce a per-lane inhibit mask. A saturating
// counter accumulates the number of inhibited lanes.
//
// Ports:
//   sys_clk    in   clock, all state on rising edge
//   reset      in   asynchronous active-high reset
//   in_valid   in   input beat present
//   in_ready   out  input beat accepted when in_valid & in_ready
//   srcz       in   source Z, lane n at [n*ZW +: ZW]
//   dstz       in   destination Z, same packing
//   lane_en    in   lane enable mask
//   zmode      in   bit0 inhibit src<dst, bit1 src==dst, bit2 src>dst
//   out_valid  out  result beat present
//   out_ready  in   result consumed when out_valid & out_ready
//   zinh       out  per-lane inhibit (1 = write inhibited)
//   zall       out  all enabled lanes inhibited and lane_en non-zero
//   cnt_clr    in   synchronous clear of inh_cnt (wins over increment)
//   inh_cnt    out  saturating count of inhibited lanes
module zcomp_pipe #(
  parameter int unsigned LANES = 4,
  parameter int unsigned ZW    = 16,
  parameter int unsigned CNTW  = 24
) (
  input  logic                  sys_clk,
  input  logic                  reset,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [LANES*ZW-1:0]   srcz,
  input  logic [LANES*ZW-1:0]   dstz,
  input  logic [LANES-1:0]      lane_en,
  input  logic [2:0]            zmode,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [LANES-1:0]      zinh,
  output logic                  zall,
  input  logic                  cnt_clr,
  output logic [CNTW-1:0]       inh_cnt
);

  localparam int unsigned PCW = $clog2(LANES + 1);
  localparam int unsigned SW  = CNTW + 1;

  // Stage A: compare flags plus the beat's own lane mask and mode
  logic             a_vld_q, a_vld_d;
  logic [LANES-1:0] a_gt_q, a_gt_d;
  logic [LANES-1:0] a_eq_q, a_eq_d;
  logic [LANES-1:0] a_lt_q, a_lt_d;
  logic [LANES-1:0] a_en_q;
  logic [2:0]       a_mode_q;

  // Stage B: final inhibit mask
  logic             b_vld_q, b_vld_d;
  logic [LANES-1:0] zinh_q, zinh_d;
  logic             zall_q, zall_d;

  logic [CNTW-1:0]  cnt_q, cnt_d;

  logic             a_ready, b_ready, a_load, b_load;
  logic [PCW-1:0]   pop;
  logic [SW-1:0]    sum;

  assign b_ready  = ~b_vld_q | out_ready;
  assign a_ready  = ~a_vld_q | b_ready;
  assign in_ready = a_ready;
  assign a_load   = in_valid & a_ready;
  assign b_load   = a_vld_q & b_ready;

  assign out_valid = b_vld_q;
  assign zinh      = zinh_q;
  assign zall      = zall_q;
  assign inh_cnt   = cnt_q;

  // Per-lane unsigned magnitude compare on the incoming beat
  always_comb begin
    a_gt_d = '0;
    a_eq_d = '0;
    a_lt_d = '0;
    for (int unsigned i = 0; i < LANES; i++) begin
      a_gt_d[i] = srcz[i*ZW +: ZW] >  dstz[i*ZW +: ZW];
      a_eq_d[i] = srcz[i*ZW +: ZW] == dstz[i*ZW +: ZW];
      a_lt_d[i] = srcz[i*ZW +: ZW] <  dstz[i*ZW +: ZW];
    end
  end

  // Valid tracking: a stage stays full only while the stage after it stalls
  always_comb begin
    a_vld_d = a_load | (a_vld_q & ~b_ready);
    b_vld_d = b_load | (b_vld_q & ~out_ready);
  end

  // Mode application uses the mode captured with the beat, not the live input
  always_comb begin
    zinh_d = a_en_q & ((a_lt_q & {LANES{a_mode_q[0]}}) |
                       (a_eq_q & {LANES{a_mode_q[1]}}) |
                       (a_gt_q & {LANES{a_mode_q[2]}}));
    zall_d = (a_en_q != '0) && (zinh_d == a_en_q);
  end

  // Saturating inhibit counter, bumped on the same edge stage B loads
  always_comb begin
    pop = '0;
    for (int unsigned i = 0; i < LANES; i++) begin
      pop = pop + PCW'(zinh_d[i]);
    end
    sum   = {1'b0, cnt_q} + SW'(pop);
    cnt_d = cnt_q;
    if (cnt_clr) begin
      cnt_d = '0;
    end else if (b_load) begin
      cnt_d = sum[CNTW] ? '1 : sum[CNTW-1:0];
    end
  end

  always_ff @(posedge sys_clk or posedge reset) begin
    if (reset) begin
      a_vld_q  <= 1'b0;
      a_gt_q   <= '0;
      a_eq_q   <= '0;
      a_lt_q   <= '0;
      a_en_q   <= '0;
      a_mode_q <= '0;
      b_vld_q  <= 1'b0;
      zinh_q   <= '0;
      zall_q   <= 1'b0;
      cnt_q    <= '0;
    end else begin
      a_vld_q <= a_vld_d;
      b_vld_q <= b_vld_d;
      cnt_q   <= cnt_d;
      if (a_load) begin
        a_gt_q   <= a_gt_d;
        a_eq_q   <= a_eq_d;
        a_lt_q   <= a_lt_d;
        a_en_q   <= lane_en;
        a_mode_q <= zmode;
      end
      if (b_load) begin
        zinh_q <= zinh_d;
        zall_q <= zall_d;
      end
    end
  end

endmodule

// File: tb/tb_zcomp_pipe.sv
// Directed bench for zcomp_pipe with an expected-result queue.
module tb_zcomp_pipe;

  logic        sys_clk = 1'b0;
  logic        reset = 1'b1;
  logic        in_valid = 1'b0;
  logic        out_ready = 1'b1;
  logic        cnt_clr = 1'b0;
  logic [63:0] srcz = '0;
  logic [63:0] dstz = '0;
  logic [3:0]  lane_en = '0;
  logic [2:0]  zmode = '0;

  logic        in_ready, out_valid, zall;
  logic [3:0]  zinh;
  logic [23:0] inh_cnt;
  logic        s_in_ready, s_out_valid, s_zall;
  logic [3:0]  s_zinh;
  logic [3:0]  s_inh_cnt;

  typedef struct packed {
    logic [3:0] zinh;
    logic       zall;
  } exp_t;

  exp_t sb[$];
  int   n_cmp = 0;
  int   n_err = 0;
  int   cnt_big = 0;
  int   cnt_small = 0;

  always #5 sys_clk = ~sys_clk;

  zcomp_pipe #(.LANES(4), .ZW(16), .CNTW(24)) u_dut (
    .sys_clk(sys_clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .srcz(srcz), .dstz(dstz), .lane_en(lane_en), .zmode(zmode),
    .out_valid(out_valid), .out_ready(out_ready), .zinh(zinh), .zall(zall),
    .cnt_clr(cnt_clr), .inh_cnt(inh_cnt)
  );

  zcomp_pipe #(.LANES(4), .ZW(16), .CNTW(4)) u_small (
    .sys_clk(sys_clk), .reset(reset), .in_valid(in_valid), .in_ready(s_in_ready),
    .srcz(srcz), .dstz(dstz), .lane_en(lane_en), .zmode(zmode),
    .out_valid(s_out_valid), .out_ready(out_ready), .zinh(s_zinh), .zall(s_zall),
    .cnt_clr(cnt_clr), .inh_cnt(s_inh_cnt)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [3:0] model_zinh(input logic [63:0] s, input logic [63:0] d,
                                            input logic [3:0] en, input logic [2:0] m);
    logic [3:0]  r;
    logic [15:0] a, b;
    r = '0;
    for (int i = 0; i < 4; i++) begin
      a = s[i*16 +: 16];
      b = d[i*16 +: 16];
      if (en[i]) begin
        if (a < b)       r[i] = m[0];
        else if (a == b) r[i] = m[1];
        else             r[i] = m[2];
      end
    end
    return r;
  endfunction

  function automatic logic [63:0] rnd_z();
    logic [63:0] v;
    v = '0;
    for (int i = 0; i < 4; i++) begin
      if ($urandom_range(0, 3) == 0) v[i*16 +: 16] = 16'($urandom);
      else                           v[i*16 +: 16] = 16'($urandom_range(0, 3));
    end
    return v;
  endfunction

  // Present a beat, wait (bounded) for acceptance, record expected result.
  task automatic drive_exp(input logic [63:0] s, input logic [63:0] d, input logic [3:0] en,
                           input logic [2:0] m, input logic [3:0] ez);
    exp_t e;
    logic acc;
    bit   done;
    int   pc;
    srcz = s; dstz = d; lane_en = en; zmode = m; in_valid = 1'b1;
    done = 1'b0;
    for (int t = 0; t < 50 && !done; t++) begin
      @(negedge sys_clk);
      acc = in_ready;
      @(posedge sys_clk);
      if (acc) begin
        e.zinh = ez;
        e.zall = (en != 4'h0) && (ez == en);
        sb.push_back(e);
        pc = $countones(ez);
        cnt_big += pc;
        cnt_small = (cnt_small + pc > 15) ? 15 : cnt_small + pc;
        done = 1'b1;
      end
    end
    #1;
    if (!done) begin
      n_cmp++;
      n_err++;
      $error("FAIL accept_timeout observed=no_accept expected=accept");
    end
  endtask

  task automatic drive(input logic [63:0] s, input logic [63:0] d, input logic [3:0] en,
                       input logic [2:0] m);
    drive_exp(s, d, en, m, model_zinh(s, d, en, m));
  endtask

  task automatic idle(input int n);
    in_valid = 1'b0;
    repeat (n) @(posedge sys_clk);
    #1;
  endtask

  task automatic check_cnt(input string tag);
    @(negedge sys_clk);
    check({tag, "_cnt"}, 64'(inh_cnt), 64'(cnt_big));
    check({tag, "_cnt_small"}, 64'(s_inh_cnt), 64'(cnt_small));
    @(posedge sys_clk);
    #1;
  endtask

  // Output monitor: scoreboard pop on transfer, hold check while stalled
  logic       prev_stall = 1'b0;
  logic [3:0] prev_zinh = '0;
  logic       prev_zall = 1'b0;
  exp_t       mon_e;

  always @(negedge sys_clk) begin
    if (!reset) begin
      if (prev_stall) begin
        check("hold_valid", 64'(out_valid), 64'd1);
        check("hold_zinh", 64'(zinh), 64'(prev_zinh));
        check("hold_zall", 64'(zall), 64'(prev_zall));
      end
      if (out_valid && out_ready) begin
        if (sb.size() == 0) begin
          n_cmp++;
          n_err++;
          $error("FAIL unexpected_beat observed=zinh_%0h expected=no_beat", zinh);
        end else begin
          mon_e = sb.pop_front();
          check("zinh", 64'(zinh), 64'(mon_e.zinh));
          check("zall", 64'(zall), 64'(mon_e.zall));
          check("small_valid", 64'(s_out_valid), 64'd1);
          check("small_zinh", 64'(s_zinh), 64'(mon_e.zinh));
          check("small_zall", 64'(s_zall), 64'(mon_e.zall));
        end
      end
    end
    prev_stall <= !reset && out_valid && !out_ready;
    prev_zinh  <= zinh;
    prev_zall  <= zall;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout observed=running expected=finished");
    $fatal(1, "global timeout");
  end

  localparam logic [63:0] S_BASIC = {16'hFFFF, 16'h3000, 16'h2000, 16'h1000};
  localparam logic [63:0] D_BASIC = {4{16'h2000}};
  localparam logic [63:0] S_LT    = {4{16'h0100}};
  localparam logic [63:0] D_LT    = {4{16'h0200}};

  logic [63:0] bp_s[6];
  logic [63:0] bp_d[6];
  logic [3:0]  held;

  initial begin
    // Reset state
    @(negedge sys_clk);
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_zinh", 64'(zinh), 64'd0);
    check("rst_zall", 64'(zall), 64'd0);
    check("rst_cnt", 64'(inh_cnt), 64'd0);
    check("rst_in_ready", 64'(in_ready), 64'd1);
    @(posedge sys_clk);
    #1 reset = 1'b0;

    // Basic modes, with latency and counter timing on the first beat
    drive_exp(S_BASIC, D_BASIC, 4'hF, 3'b001, 4'b0001);
    in_valid = 1'b0;
    @(negedge sys_clk);
    check("lat_early", 64'(out_valid), 64'd0);
    @(negedge sys_clk);
    check("lat_valid", 64'(out_valid), 64'd1);
    check("lat_cnt", 64'(inh_cnt), 64'd1);
    @(posedge sys_clk);
    #1;
    drive_exp(S_BASIC, D_BASIC, 4'hF, 3'b110, 4'b1110);
    drive_exp(S_BASIC, D_BASIC, 4'hF, 3'b111, 4'b1111);
    idle(4);
    check_cnt("basic");

    // Lane mask, including empty mask
    drive_exp(S_BASIC, D_BASIC, 4'b0101, 3'b111, 4'b0101);
    drive_exp(S_BASIC, D_BASIC, 4'b0000, 3'b111, 4'b0000);
    idle(4);
    check_cnt("mask");

    // Mode captured per beat
    drive_exp(S_LT, D_LT, 4'hF, 3'b001, 4'hF);
    drive_exp(S_LT, D_LT, 4'hF, 3'b100, 4'h0);
    drive_exp(S_LT, D_LT, 4'hF, 3'b001, 4'hF);
    drive_exp(S_LT, D_LT, 4'hF, 3'b100, 4'h0);
    idle(4);
    check_cnt("mode");

    // Back-pressure: two accepts fill the pipe, then in_ready must stay low
    for (int i = 0; i < 6; i++) begin
      bp_s[i] = {16'(i * 7), 16'(i), 16'h0400, 16'(16'h0200 * i)};
      bp_d[i] = {16'h0007, 16'h0002, 16'(16'h0100 * i), 16'h0400};
    end
    out_ready = 1'b0;
    drive(bp_s[0], bp_d[0], 4'hF, 3'(1 + 0));
    drive(bp_s[1], bp_d[1], 4'hF, 3'(1 + 1));
    srcz = bp_s[2];
    dstz = bp_d[2];
    lane_en = 4'hF;
    zmode = 3'd3;
    @(negedge sys_clk);
    held = zinh;
    check("bp_held_first", 64'(held), 64'(model_zinh(bp_s[0], bp_d[0], 4'hF, 3'd1)));
    for (int c = 0; c < 3; c++) begin
      if (c != 0) @(negedge sys_clk);
      check("bp_in_ready", 64'(in_ready), 64'd0);
      check("bp_small_in_ready", 64'(s_in_ready), 64'd0);
      check("bp_zinh_held", 64'(zinh), 64'(held));
    end
    @(posedge sys_clk);
    #1 out_ready = 1'b1;
    fork
      begin
        for (int i = 2; i < 6; i++) drive(bp_s[i], bp_d[i], 4'hF, 3'(1 + i));
        in_valid = 1'b0;
      end
      begin
        for (int c = 0; c < 6; c++) begin
          @(negedge sys_clk);
          check("tput_valid", 64'(out_valid), 64'd1);
        end
      end
    join
    idle(4);
    check_cnt("bp");

    // Random data under random back-pressure
    fork
      begin
        for (int i = 0; i < 20; i++)
          drive(rnd_z(), rnd_z(), 4'($urandom_range(0, 15)), 3'($urandom_range(0, 7)));
        in_valid = 1'b0;
      end
      begin
        for (int c = 0; c < 40; c++) begin
          out_ready = 1'($urandom_range(0, 1));
          @(posedge sys_clk);
          #1;
        end
        out_ready = 1'b1;
      end
    join
    idle(6);
    check_cnt("rand");

    // cnt_clr on the edge where stage B loads wins over the increment
    drive_exp(S_BASIC, D_BASIC, 4'hF, 3'b111, 4'hF);
    in_valid = 1'b0;
    cnt_clr = 1'b1;
    @(posedge sys_clk);
    #1 cnt_clr = 1'b0;
    cnt_big = 0;
    cnt_small = 0;
    @(negedge sys_clk);
    check("clr_valid", 64'(out_valid), 64'd1);
    check("clr_cnt", 64'(inh_cnt), 64'd0);
    check("clr_cnt_small", 64'(s_inh_cnt), 64'd0);
    @(posedge sys_clk);
    #1;

    // Saturation of the narrow counter: 12 then 20 lanes
    for (int i = 0; i < 3; i++) drive_exp(S_BASIC, D_BASIC, 4'hF, 3'b111, 4'hF);
    idle(4);
    check_cnt("sat_pre");
    for (int i = 0; i < 2; i++) drive_exp(S_BASIC, D_BASIC, 4'hF, 3'b111, 4'hF);
    idle(4);
    check_cnt("sat");
    check("sat_small_max", 64'(s_inh_cnt), 64'd15);

    // Reset with both stages full
    out_ready = 1'b0;
    drive(bp_s[3], bp_d[3], 4'hF, 3'b011);
    drive(bp_s[4], bp_d[4], 4'hF, 3'b110);
    reset = 1'b1;
    in_valid = 1'b0;
    #1;
    check("mrst_out_valid", 64'(out_valid), 64'd0);
    check("mrst_zinh", 64'(zinh), 64'd0);
    check("mrst_zall", 64'(zall), 64'd0);
    check("mrst_cnt", 64'(inh_cnt), 64'd0);
    check("mrst_cnt_small", 64'(s_inh_cnt), 64'd0);
    check("mrst_in_ready", 64'(in_ready), 64'd1);
    sb.delete();
    cnt_big = 0;
    cnt_small = 0;
    @(posedge sys_clk);
    #1;
    check("mrst_in_ready_held", 64'(in_ready), 64'd1);
    reset = 1'b0;
    out_ready = 1'b1;
    drive_exp(S_LT, D_LT, 4'b1011, 3'b001, 4'b1011);
    in_valid = 1'b0;
    @(negedge sys_clk);
    check("post_rst_early", 64'(out_valid), 64'd0);
    @(negedge sys_clk);
    check("post_rst_valid", 64'(out_valid), 64'd1);
    @(posedge sys_clk);
    #1;
    idle(3);
    check_cnt("post_rst");
    check("sb_empty", 64'(sb.size()), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
